// File: rtl/instr_fetch_if.sv
// Instruction-memory read channel between the fetch stage and instruction memory.
//   imem_req   : fetch stage is requesting the word at imem_addr
//   imem_addr  : byte address of the requested word (always the current pc)
//   imem_ack   : memory returns imem_rdata this cycle (meaningful only while imem_req=1)
//   imem_rdata : instruction word returned with imem_ack
// master = fetch stage, slave = memory.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage with IF/ID register and a one-entry skid buffer.
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   imem            : instruction-memory read channel (master side)
//   stall           : downstream cannot take a new instruction this cycle
//   branch_taken    : redirect from execute, branch_target is the new pc
//   id_valid/instr/pc : IF/ID register contents
//   opcode, funct   : combinational decode slices of id_instr
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_if.master       imem,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [31:0]         branch_target,
  output logic                id_valid,
  output logic [31:0]         id_instr,
  output logic [31:0]         id_pc,
  output logic [3:0]          opcode,
  output logic [2:0]          funct
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      r_state,     w_state_nxt;
  logic [31:0] r_pc,        w_pc_nxt;
  logic        r_id_valid,  w_id_valid_nxt;
  logic [31:0] r_id_instr,  w_id_instr_nxt;
  logic [31:0] r_id_pc,     w_id_pc_nxt;
  logic [31:0] r_skid_instr, w_skid_instr_nxt;
  logic [31:0] r_skid_pc,    w_skid_pc_nxt;

  assign imem.imem_req  = (r_state == FETCH);
  assign imem.imem_addr = r_pc;

  assign id_valid = r_id_valid;
  assign id_instr = r_id_instr;
  assign id_pc    = r_id_pc;
  assign opcode   = r_id_instr[31:28];
  assign funct    = r_id_instr[2:0];

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_id_valid_nxt   = r_id_valid;
    w_id_instr_nxt   = r_id_instr;
    w_id_pc_nxt      = r_id_pc;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;

    if (branch_taken) begin
      // Redirect wins over stall; any ack this cycle and the skid entry are dropped.
      // Leaving HOLD is what empties the skid buffer.
      w_state_nxt    = FETCH;
      w_pc_nxt       = {branch_target[31:2], 2'b00};
      w_id_valid_nxt = 1'b0;
      w_id_instr_nxt = '0;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = FETCH;
        FETCH: begin
          if (imem.imem_ack) begin
            // Accepted word always advances pc (mod 2^32 via natural wrap).
            w_pc_nxt = r_pc + 32'(PC_STEP);
            if (stall) begin
              w_skid_instr_nxt = imem.imem_rdata;
              w_skid_pc_nxt    = r_pc;
              w_state_nxt      = HOLD;
            end else begin
              w_id_instr_nxt = imem.imem_rdata;
              w_id_pc_nxt    = r_pc;
              w_id_valid_nxt = 1'b1;
            end
          end else if (!stall) begin
            w_id_valid_nxt = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            w_id_instr_nxt = r_skid_instr;
            w_id_pc_nxt    = r_skid_pc;
            w_id_valid_nxt = 1'b1;
            w_state_nxt    = FETCH;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_id_valid   <= 1'b0;
      r_id_instr   <= '0;
      r_id_pc      <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_id_valid   <= w_id_valid_nxt;
      r_id_instr   <= w_id_instr_nxt;
      r_id_pc      <= w_id_pc_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_taken;
  logic [31:0] branch_target;
  logic        id_valid;
  logic [31:0] id_instr, id_pc;
  logic [3:0]  opcode;
  logic [2:0]  funct;

  instr_fetch_if u_if ();

  instr_fetch #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset), .imem(u_if), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .opcode(opcode), .funct(funct)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One row = inputs applied for one clock edge, then outputs expected after it.
  typedef struct {
    logic        rst, ack, stl, br;
    logic [31:0] tgt, rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr, e_pc;
    logic        chk_pc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic ack, logic stl, logic br, logic [31:0] tgt,
                              logic [31:0] rdata, logic e_req, logic [31:0] e_addr,
                              logic e_vld, logic [31:0] e_instr, logic [31:0] e_pc,
                              logic chk_pc);
    vec_t v;
    v.rst = rst; v.ack = ack; v.stl = stl; v.br = br; v.tgt = tgt; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_instr = e_instr;
    v.e_pc = e_pc; v.chk_pc = chk_pc;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic ack, input logic stl, input logic br,
                       input logic [31:0] tgt, input logic [31:0] rdata);
    reset = rst; u_if.imem_ack = ack; stall = stl; branch_taken = br;
    branch_target = tgt; u_if.imem_rdata = rdata;
  endtask

  task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_vld, input logic [31:0] e_instr,
                            input logic [31:0] e_pc, input logic chk_pc);
    chk({tag, ".req"},    32'(u_if.imem_req), 32'(e_req));
    chk({tag, ".addr"},   u_if.imem_addr, e_addr);
    chk({tag, ".valid"},  32'(id_valid), 32'(e_vld));
    chk({tag, ".instr"},  id_instr, e_instr);
    chk({tag, ".opcode"}, 32'(opcode), 32'(e_instr[31:28]));
    chk({tag, ".funct"},  32'(funct), 32'(e_instr[2:0]));
    if (chk_pc) chk({tag, ".id_pc"}, id_pc, e_pc);
  endtask

  // Reference model: fetch is idle for one cycle after reset, then requests whenever
  // no instruction is parked waiting for downstream.
  bit          m_warm;
  logic [31:0] m_pc, m_instr, m_idpc;
  bit          m_vld, m_pc_known;
  logic [63:0] m_skid[$];

  task automatic model_step(input logic rst, input logic ack, input logic stl, input logic br,
                            input logic [31:0] tgt, input logic [31:0] rdata);
    logic [63:0] e;
    if (rst) begin
      m_pc = 32'h0; m_warm = 1; m_skid.delete(); m_vld = 0; m_instr = 0; m_idpc = 0;
      m_pc_known = 1;
    end else if (br) begin
      m_pc = tgt & 32'hFFFF_FFFC; m_warm = 0; m_skid.delete(); m_vld = 0; m_instr = 0;
      m_pc_known = 0;
    end else if (m_warm) begin
      m_warm = 0;
    end else if (m_skid.size() != 0) begin
      if (!stl) begin
        e = m_skid.pop_front();
        m_instr = e[63:32]; m_idpc = e[31:0]; m_vld = 1; m_pc_known = 1;
      end
    end else if (ack) begin
      if (stl) m_skid.push_back({rdata, m_pc});
      else begin m_instr = rdata; m_idpc = m_pc; m_vld = 1; m_pc_known = 1; end
      m_pc = m_pc + 32'd4;
    end else if (!stl) begin
      m_vld = 0;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    //        rst ack stl br  tgt            rdata          req addr           vld instr          idpc          chkpc
    vt.push_back(mk(1,0,0,0, 32'h0,         32'h0,         0, 32'h0,         0, 32'h0,         32'h0,        1));
    vt.push_back(mk(0,0,0,0, 32'h0,         32'h0,         1, 32'h0,         0, 32'h0,         32'h0,        1));
    vt.push_back(mk(0,1,0,0, 32'h0,         32'h1000_0003, 1, 32'h4,         1, 32'h1000_0003, 32'h0,        1));
    vt.push_back(mk(0,1,0,0, 32'h0,         32'h2000_0001, 1, 32'h8,         1, 32'h2000_0001, 32'h4,        1));
    vt.push_back(mk(0,1,1,0, 32'h0,         32'hA000_0005, 0, 32'hC,         1, 32'h2000_0001, 32'h4,        1));
    vt.push_back(mk(0,1,1,0, 32'h0,         32'hDEAD_BEEF, 0, 32'hC,         1, 32'h2000_0001, 32'h4,        1));
    vt.push_back(mk(0,0,1,0, 32'h0,         32'h0,         0, 32'hC,         1, 32'h2000_0001, 32'h4,        1));
    vt.push_back(mk(0,0,0,0, 32'h0,         32'h0,         1, 32'hC,         1, 32'hA000_0005, 32'h8,        1));
    vt.push_back(mk(0,1,0,0, 32'h0,         32'h3000_0002, 1, 32'h10,        1, 32'h3000_0002, 32'hC,        1));
    vt.push_back(mk(0,0,0,0, 32'h0,         32'h0,         1, 32'h10,        0, 32'h3000_0002, 32'hC,        1));
    vt.push_back(mk(0,0,0,0, 32'h0,         32'h0,         1, 32'h10,        0, 32'h3000_0002, 32'hC,        1));
    vt.push_back(mk(0,1,0,0, 32'h0,         32'h4000_0004, 1, 32'h14,        1, 32'h4000_0004, 32'h10,       1));
    vt.push_back(mk(0,0,1,0, 32'h0,         32'h0,         1, 32'h14,        1, 32'h4000_0004, 32'h10,       1));
    vt.push_back(mk(0,1,1,1, 32'h0000_0103, 32'h5555_5555, 1, 32'h100,       0, 32'h0,         32'h0,        0));
    vt.push_back(mk(0,1,0,0, 32'h0,         32'h6000_0006, 1, 32'h104,       1, 32'h6000_0006, 32'h100,      1));
    vt.push_back(mk(0,0,0,1, 32'hFFFF_FFFE, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,        0));
    vt.push_back(mk(0,1,0,0, 32'h0,         32'h7000_0007, 1, 32'h0,         1, 32'h7000_0007, 32'hFFFF_FFFC,1));
    vt.push_back(mk(0,1,1,0, 32'h0,         32'h8000_0001, 0, 32'h4,         1, 32'h7000_0007, 32'hFFFF_FFFC,1));
    vt.push_back(mk(1,0,1,0, 32'h0,         32'h0,         0, 32'h0,         0, 32'h0,         32'h0,        1));
    vt.push_back(mk(0,0,0,0, 32'h0,         32'h0,         1, 32'h0,         0, 32'h0,         32'h0,        1));
    vt.push_back(mk(0,1,0,0, 32'h0,         32'h9000_0002, 1, 32'h4,         1, 32'h9000_0002, 32'h0,        1));
    vt.push_back(mk(0,1,1,0, 32'h0,         32'hB000_0003, 0, 32'h8,         1, 32'h9000_0002, 32'h0,        1));
    vt.push_back(mk(0,0,1,1, 32'h0000_0040, 32'h0,         1, 32'h40,        0, 32'h0,         32'h0,        0));
    vt.push_back(mk(0,1,0,0, 32'h0,         32'hC000_0004, 1, 32'h44,        1, 32'hC000_0004, 32'h40,       1));

    @(negedge clk);
    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].ack, vt[i].stl, vt[i].br, vt[i].tgt, vt[i].rdata);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_vld,
                 vt[i].e_instr, vt[i].e_pc, vt[i].chk_pc);
    end

    // Hand sequence: reset while parked in HOLD, then restart from RESET_PC.
    drive(0, 1, 1, 0, 0, 32'hE000_0007);          // ack+stall at 0x44 -> HOLD
    @(negedge clk);
    check_outs("hold_entry", 0, 32'h48, 1, 32'hC000_0004, 32'h40, 1);
    drive(1, 0, 1, 0, 0, 0);
    @(negedge clk);
    check_outs("hold_reset", 0, 32'h0, 0, 32'h0, 32'h0, 1);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_outs("post_reset_idle", 1, 32'h0, 0, 32'h0, 32'h0, 1);
    drive(0, 1, 0, 0, 0, 32'hF000_0006);
    @(negedge clk);
    check_outs("post_reset_fetch", 1, 32'h4, 1, 32'hF000_0006, 32'h0, 1);

    // Randomized run against the reference model, starting from a reset.
    drive(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      logic r_rst, r_ack, r_stl, r_br;
      logic [31:0] r_tgt, r_dat;
      check_outs($sformatf("rnd%0d", c), !m_warm && m_skid.size() == 0, m_pc, m_vld,
                 m_instr, m_idpc, m_pc_known);
      r_rst = ($urandom_range(99) < 2);
      r_br  = ($urandom_range(99) < 8);
      r_ack = ($urandom_range(99) < 60);
      r_stl = ($urandom_range(99) < 35);
      r_tgt = $urandom;
      if ($urandom_range(9) == 0) r_tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      r_dat = $urandom;
      drive(r_rst, r_ack, r_stl, r_br, r_tgt, r_dat);
      model_step(r_rst, r_ack, r_stl, r_br, r_tgt, r_dat);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
